// File: rtl/mem_indirect_ctrl.sv
// MEM-stage data-access sequencer: issues one data-memory access per load/store,
// or two for LDI/STI (pointer fetch, then access), stalling the pipeline until done.
module mem_indirect_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        valid_in,
    input  logic [3:0]  opcode,
    input  logic [15:0] addr_in,
    input  logic [15:0] wdata_in,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [15:0] dmem_address,
    output logic [15:0] dmem_wdata,
    output logic [1:0]  dmem_byte_enable,
    output logic        mem_stall,
    output logic [15:0] load_data,
    output logic        load_valid
);

    localparam logic [3:0] OP_LDB = 4'b0010;
    localparam logic [3:0] OP_STB = 4'b0011;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;

    typedef enum logic [1:0] {IDLE, PTR, DATA, DONE} state_t;

    state_t      state, state_next;
    logic [3:0]  op_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] ptr_reg;
    logic        in_mem_op;
    logic        op_load, op_ind, op_ldb, op_stb;
    logic [15:0] acc_addr;

    assign in_mem_op = valid_in && ((opcode == OP_LDB) || (opcode == OP_STB) ||
                                    (opcode == OP_LDR) || (opcode == OP_STR) ||
                                    (opcode == OP_LDI) || (opcode == OP_STI));

    assign op_ldb   = (op_q == OP_LDB);
    assign op_stb   = (op_q == OP_STB);
    assign op_load  = op_ldb || (op_q == OP_LDR) || (op_q == OP_LDI);
    assign op_ind   = (op_q == OP_LDI) || (op_q == OP_STI);
    assign acc_addr = op_ind ? ptr_reg : addr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            op_q      <= 4'h0;
            addr_q    <= 16'h0000;
            wdata_q   <= 16'h0000;
            ptr_reg   <= 16'h0000;
            load_data <= 16'h0000;
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (in_mem_op) begin
                    op_q    <= opcode;
                    addr_q  <= addr_in;
                    wdata_q <= wdata_in;
                end
                PTR: if (dmem_resp) ptr_reg <= dmem_rdata;
                DATA: if (dmem_resp && op_load) begin
                    // LDB takes the byte lane selected by the original (non-pointer) address
                    if (op_ldb)
                        load_data <= {8'h00, addr_q[0] ? dmem_rdata[15:8] : dmem_rdata[7:0]};
                    else
                        load_data <= dmem_rdata;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next       = state;
        dmem_read        = 1'b0;
        dmem_write       = 1'b0;
        dmem_address     = 16'h0000;
        dmem_wdata       = 16'h0000;
        dmem_byte_enable = 2'b00;
        mem_stall        = 1'b0;
        load_valid       = 1'b0;
        case (state)
            IDLE: begin
                // Gated by reset_n so the stall drops the instant reset is asserted
                if (in_mem_op && reset_n) begin
                    mem_stall  = 1'b1;
                    state_next = ((opcode == OP_LDI) || (opcode == OP_STI)) ? PTR : DATA;
                end
            end
            PTR: begin
                mem_stall        = 1'b1;
                dmem_read        = 1'b1;
                dmem_address     = {addr_q[15:1], 1'b0};
                dmem_byte_enable = 2'b11;
                if (dmem_resp) state_next = DATA;
            end
            DATA: begin
                mem_stall    = 1'b1;
                dmem_address = {acc_addr[15:1], 1'b0};
                if (op_load) begin
                    dmem_read        = 1'b1;
                    dmem_byte_enable = 2'b11;
                end else if (op_stb) begin
                    dmem_write       = 1'b1;
                    dmem_wdata       = {wdata_q[7:0], wdata_q[7:0]};
                    dmem_byte_enable = addr_q[0] ? 2'b10 : 2'b01;
                end else begin
                    dmem_write       = 1'b1;
                    dmem_wdata       = wdata_q;
                    dmem_byte_enable = 2'b11;
                end
                if (dmem_resp) state_next = DONE;
            end
            DONE: begin
                load_valid = op_load;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_indirect_ctrl.sv
// Randomized bench for mem_indirect_ctrl: a word-level memory model computes each
// instruction's expected transactions, stall length and load result.
module tb_mem_indirect_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        valid_in;
    logic [3:0]  opcode;
    logic [15:0] addr_in;
    logic [15:0] wdata_in;
    logic [15:0] dmem_rdata;
    logic        dmem_resp;
    logic        dmem_read;
    logic        dmem_write;
    logic [15:0] dmem_address;
    logic [15:0] dmem_wdata;
    logic [1:0]  dmem_byte_enable;
    logic        mem_stall;
    logic [15:0] load_data;
    logic        load_valid;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mem [logic [15:0]];
    logic [15:0] exp_q[$];
    logic [15:0] last_load = 16'h0000;

    mem_indirect_ctrl dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .valid_in         (valid_in),
        .opcode           (opcode),
        .addr_in          (addr_in),
        .wdata_in         (wdata_in),
        .dmem_rdata       (dmem_rdata),
        .dmem_resp        (dmem_resp),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_address     (dmem_address),
        .dmem_wdata       (dmem_wdata),
        .dmem_byte_enable (dmem_byte_enable),
        .mem_stall        (mem_stall),
        .load_data        (load_data),
        .load_valid       (load_valid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        return mem.exists(a) ? mem[a] : (a ^ 16'h5A5A);
    endfunction

    // One instruction through MEM; waits = wait cycles before each response.
    task automatic run_op(input logic v, input logic [3:0] op, input logic [15:0] addr,
                          input logic [15:0] wd, input int waits);
        logic        is_mem, is_load, ind;
        logic [15:0] fin, word, tmp, old;
        int          n_acc, stall_seen;
        logic        acc_rd [2];
        logic [15:0] acc_a  [2];
        logic [15:0] acc_wd [2];
        logic [1:0]  acc_be [2];

        is_mem  = v && (op inside {4'b0010, 4'b0011, 4'b0110, 4'b0111, 4'b1010, 4'b1011});
        is_load = op inside {4'b0010, 4'b0110, 4'b1010};
        ind     = op inside {4'b1010, 4'b1011};
        n_acc   = 0;
        fin     = addr;
        if (is_mem && ind) begin
            acc_rd[0] = 1'b1;
            acc_a[0]  = {addr[15:1], 1'b0};
            acc_be[0] = 2'b11;
            acc_wd[0] = 16'h0000;
            fin       = mem_rd(acc_a[0]);
            n_acc     = 1;
        end
        word = {fin[15:1], 1'b0};
        if (is_mem) begin
            acc_a[n_acc] = word;
            if (is_load) begin
                acc_rd[n_acc] = 1'b1;
                acc_be[n_acc] = 2'b11;
                acc_wd[n_acc] = 16'h0000;
                tmp = mem_rd(word);
                if (op == 4'b0010)
                    exp_q.push_back({8'h00, fin[0] ? tmp[15:8] : tmp[7:0]});
                else
                    exp_q.push_back(tmp);
            end else if (op == 4'b0011) begin
                acc_rd[n_acc] = 1'b0;
                acc_be[n_acc] = fin[0] ? 2'b10 : 2'b01;
                acc_wd[n_acc] = {wd[7:0], wd[7:0]};
            end else begin
                acc_rd[n_acc] = 1'b0;
                acc_be[n_acc] = 2'b11;
                acc_wd[n_acc] = wd;
            end
            n_acc++;
        end

        @(negedge clk);
        valid_in = v; opcode = op; addr_in = addr; wdata_in = wd; dmem_resp = 1'b0;
        #1;
        check_eq("idle_stall", {15'd0, mem_stall}, {15'd0, is_mem});
        check_eq("idle_read", {15'd0, dmem_read}, 16'd0);
        check_eq("idle_write", {15'd0, dmem_write}, 16'd0);
        check_eq("idle_load_valid", {15'd0, load_valid}, 16'd0);
        stall_seen = mem_stall ? 1 : 0;
        if (!is_mem) return;

        for (int a = 0; a < n_acc; a++) begin
            for (int w = 0; w <= waits; w++) begin
                @(negedge clk);
                dmem_resp = 1'b0;
                #1;
                if (mem_stall) stall_seen++;
                check_eq("acc_read", {15'd0, dmem_read}, {15'd0, acc_rd[a]});
                check_eq("acc_write", {15'd0, dmem_write}, {15'd0, !acc_rd[a]});
                check_eq("acc_addr", dmem_address, acc_a[a]);
                check_eq("acc_be", {14'd0, dmem_byte_enable}, {14'd0, acc_be[a]});
                if (!acc_rd[a]) check_eq("acc_wdata", dmem_wdata, acc_wd[a]);
                if (w == waits) begin
                    dmem_resp  = 1'b1;
                    dmem_rdata = mem_rd(dmem_address);
                    if (!acc_rd[a]) begin
                        old = mem_rd(acc_a[a]);
                        if (acc_be[a] == 2'b11)      mem[acc_a[a]] = acc_wd[a];
                        else if (acc_be[a] == 2'b10) mem[acc_a[a]] = {acc_wd[a][15:8], old[7:0]};
                        else                         mem[acc_a[a]] = {old[15:8], acc_wd[a][7:0]};
                    end
                end
            end
        end

        @(negedge clk);
        dmem_resp  = 1'b0;
        dmem_rdata = 16'($urandom);
        #1;
        check_eq("done_stall", {15'd0, mem_stall}, 16'd0);
        check_eq("done_read", {15'd0, dmem_read}, 16'd0);
        check_eq("done_write", {15'd0, dmem_write}, 16'd0);
        check_eq("done_load_valid", {15'd0, load_valid}, {15'd0, is_load});
        if (is_load && exp_q.size() > 0) last_load = exp_q.pop_front();
        check_eq("load_data", load_data, last_load);
        check_eq("stall_cycles", 16'(stall_seen), 16'(1 + n_acc * (waits + 1)));
    endtask

    initial begin
        logic [3:0] op_tab [8];
        op_tab = '{4'b0010, 4'b0011, 4'b0110, 4'b0111, 4'b1010, 4'b1011, 4'b0001, 4'b1100};

        reset_n = 1'b0; valid_in = 1'b0; opcode = 4'h0; addr_in = 16'h0;
        wdata_in = 16'h0; dmem_rdata = 16'h0; dmem_resp = 1'b0;
        #1;
        check_eq("rst_read", {15'd0, dmem_read}, 16'd0);
        check_eq("rst_write", {15'd0, dmem_write}, 16'd0);
        check_eq("rst_addr", dmem_address, 16'h0000);
        check_eq("rst_wdata", dmem_wdata, 16'h0000);
        check_eq("rst_be", {14'd0, dmem_byte_enable}, 16'd0);
        check_eq("rst_stall", {15'd0, mem_stall}, 16'd0);
        check_eq("rst_load_valid", {15'd0, load_valid}, 16'd0);
        check_eq("rst_load_data", load_data, 16'h0000);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        mem[16'h3000] = 16'h1234;
        run_op(1'b1, 4'b0110, 16'h3001, 16'h0000, 0);
        mem[16'h3000] = 16'hABCD;
        run_op(1'b1, 4'b0010, 16'h3001, 16'h0000, 0);
        run_op(1'b1, 4'b0010, 16'h3000, 16'h0000, 1);
        run_op(1'b1, 4'b0011, 16'h4001, 16'h5566, 0);
        mem[16'h2000] = 16'h5000;
        mem[16'h5000] = 16'hBEEF;
        run_op(1'b1, 4'b1010, 16'h2000, 16'h0000, 2);
        mem[16'h2000] = 16'h6002;
        run_op(1'b1, 4'b1011, 16'h2000, 16'h0F0F, 0);
        run_op(1'b1, 4'b0001, 16'h1234, 16'h0000, 0);

        // Reset during the pointer-fetch wait of an LDI
        mem[16'h2000] = 16'h5000;
        @(negedge clk);
        valid_in = 1'b1; opcode = 4'b1010; addr_in = 16'h2000; dmem_resp = 1'b0;
        @(negedge clk);
        #1;
        check_eq("ptr_read", {15'd0, dmem_read}, 16'd1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_eq("abort_read", {15'd0, dmem_read}, 16'd0);
        check_eq("abort_stall", {15'd0, mem_stall}, 16'd0);
        check_eq("abort_load_valid", {15'd0, load_valid}, 16'd0);
        check_eq("abort_load_data", load_data, 16'h0000);
        last_load = 16'h0000;
        @(negedge clk);
        reset_n = 1'b1; valid_in = 1'b0;
        #1;
        check_eq("post_rst_stall", {15'd0, mem_stall}, 16'd0);
        check_eq("post_rst_read", {15'd0, dmem_read}, 16'd0);
        run_op(1'b1, 4'b1010, 16'h2000, 16'h0000, 1);

        for (int i = 0; i < 150; i++) begin
            run_op($urandom_range(0, 7) != 0, op_tab[$urandom_range(0, 7)],
                   16'h3000 | 16'($urandom_range(0, 63)), 16'($urandom),
                   $urandom_range(0, 3));
        end

        @(negedge clk);
        valid_in = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_indirect_ctrl.md
# mem_indirect_ctrl

Memory-stage data-access sequencer for the pipelined LC-3b datapath. Sits between the MEM pipeline register and the data-memory port (the `mem_resp_b` side). Turns each load/store in MEM into one or two data-memory transactions: LDI/STI fetch a pointer first, then access it. Holds `mem_stall` to freeze the pipeline until the final transaction completes, and delivers aligned, byte-extracted load data to write-back.

## Interface
Parameters:
- none; all widths are fixed by `lc3b_types` (word = 16 bits, opcode = 4 bits).

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- valid_in  in  1  MEM stage holds a valid instruction
- opcode  in  4  `lc3b_opcode` of the MEM-stage instruction
- addr_in  in  16  effective address from EX (byte address)
- wdata_in  in  16  store source register value
- dmem_rdata  in  16  data-memory read data
- dmem_resp  in  1  data-memory response; one cycle completes the current request
- dmem_read  out  1  read request
- dmem_write  out  1  write request
- dmem_address  out  16  request address, bit 0 always 0
- dmem_wdata  out  16  write data
- dmem_byte_enable  out  2  [1] high byte, [0] low byte
- mem_stall  out  1  freeze IF..MEM pipeline registers
- load_data  out  16  final load result for WB
- load_valid  out  1  load_data is valid for the instruction now leaving MEM

## Operation
- Memory ops: LDB 0010, STB 0011, LDR 0110, STR 0111, LDI 1010, STI 1011. All other opcodes, or valid_in=0, are non-memory: no request, no stall.
- FSM states: IDLE, PTR, DATA, DONE.
- IDLE: on valid memory op, latch opcode, addr_in and wdata_in into internal registers. Go to PTR for LDI/STI, otherwise DATA. No request is issued in this cycle.
- PTR: read, word access at latched addr[15:1],0 with byte_enable 11. On dmem_resp, latch dmem_rdata into ptr_reg and go to DATA. Otherwise stay in PTR.
- DATA: the access address is ptr_reg for LDI/STI, latched addr otherwise. Bit 0 is cleared on the bus.
  - Loads (LDR/LDI/LDB): read.
  - Stores (STR/STI): write wdata, byte_enable 11.
  - STB: write {wdata[7:0],wdata[7:0]}, byte_enable 10 if addr[0]=1, else 01.
  - On dmem_resp, go to DONE.
  - For loads, also capture load_data: the full word for LDR/LDI; {8'h00, addr[0] ? rdata[15:8] : rdata[7:0]} for LDB.
- DONE: no request, stall 0, so the pipeline advances at the end of this cycle. load_valid=1 if the op was a load. The instruction still visible on the inputs is ignored. Always go to IDLE.
- mem_stall = (IDLE & valid memory op) | PTR | DATA.
- Request outputs are decoded from state and latched registers only. They stay stable until dmem_resp.
- dmem_resp in IDLE or DONE is ignored.
- load_data holds its value until the next load capture.

## Timing
- Reset (async, takes effect immediately): state=IDLE, ptr_reg=0, load_data=0. All requests, mem_stall and load_valid are 0, dmem_address=0, dmem_wdata=0, dmem_byte_enable=00.
- Reset asserted mid-transaction: requests drop in the same cycle. The aborted access is not replayed.
- Zero-wait memory (resp in the first request cycle):
  - LDR/STR/LDB/STB: 3 cycles in MEM (IDLE, DATA, DONE), 2 stall cycles.
  - LDI/STI: 4 cycles, 3 stall cycles.
- Each wait cycle without dmem_resp adds exactly one cycle in the current state.
- Back-to-back memory ops: after DONE, the next instruction is seen in IDLE on the following cycle. There is no bubble beyond the IDLE cycle.
- dmem_read and dmem_write are never both 1.

## Test plan
- LDR, addr_in=0x3001, memory word 0x1234 at 0x3000, zero wait -> dmem_address=0x3000, byte_enable 11; mem_stall high for 2 cycles; DONE shows load_valid=1, load_data=0x1234.
- LDB, addr_in=0x3001, word 0xABCD -> load_data=0x00AB. With addr_in=0x3000 -> 0x00CD.
- STB, addr_in=0x4001, wdata_in=0x5566 -> single write, address 0x4000, wdata 0x6666, byte_enable 10; stall 2 cycles; load_valid stays 0.
- LDI, addr_in=0x2000, mem[0x2000]=0x5000, mem[0x5000]=0xBEEF, 2 wait cycles per access -> reads 0x2000 then 0x5000; stall 7 cycles; load_data=0xBEEF.
- STI, addr_in=0x2000, mem[0x2000]=0x6002, wdata_in=0x0F0F -> read 0x2000, then write 0x6002 with 0x0F0F, byte_enable 11.
- Assert reset_n=0 during LDI PTR wait -> dmem_read, mem_stall and load_valid go to 0 immediately; after release, state is IDLE. A non-memory opcode with valid_in=1 -> stall 0, no request.
